speckle_scan_sequencer: RTL and testbench

//  Parametrised pixel-scan engine for the speckle sensor array. Drives the chip row/col shift registers

---
 rtl/speckle_scan_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_speckle_scan_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speckle_scan_sequencer.sv
// Row/column pixel-scan engine: clocks the sensor shift registers via a tick divider, triggers one
// ADC conversion per pixel, writes samples to frame RAM. Define SSC_ADC_TIMEOUT_EN for ADC timeout.
module speckle_scan_sequencer #(
  parameter int unsigned COLS         = 24,
  parameter int unsigned ROWS         = 24,
  parameter int unsigned NB_DATA      = 12,
  parameter int unsigned NB_DIV       = 24,
  parameter int unsigned SETTLE_TICKS = 2,
  parameter int unsigned TIMEOUT      = 1024,
  localparam int unsigned NB_ADDR     = $clog2(COLS * ROWS)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_continuous,
  input  logic               i_abort,
  input  logic [NB_DIV-1:0]  i_clk_div,
  input  logic [NB_DATA-1:0] i_umbral,
  input  logic [NB_DATA-1:0] i_adc_val,
  input  logic               i_adc_done,
  output logic               o_adc_trigger,
  output logic               o_chip_row_clk,
  output logic               o_chip_row_rst,
  output logic               o_chip_row_data,
  output logic               o_chip_row_ena,
  output logic               o_chip_col_clk,
  output logic               o_chip_col_rst,
  output logic               o_chip_col_data,
  output logic               o_chip_key_wren,
  output logic               o_key_bit,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_adc_err
);

  localparam int unsigned NB_COL = $clog2(COLS);
  localparam int unsigned NB_ROW = $clog2(ROWS);
  localparam int unsigned NB_PH  = $clog2(SETTLE_TICKS + 3);

  if (COLS < 2 || ROWS < 2 || SETTLE_TICKS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("speckle_scan_sequencer: illegal parameter value");
  end

  typedef enum logic [3:0] {
    StIdle, StRowRst, StRowShift, StColRst, StColShift, StSettle, StConvert, StWrite, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DIV-1:0]  div_q, div_d;
  logic [NB_PH-1:0]   ph_q, ph_d;
  logic [NB_ROW-1:0]  row_q, row_d;
  logic [NB_COL-1:0]  col_q, col_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] sample_q, sample_d;
  logic               trig_q, trig_d;
  logic               err_q, err_d;
  logic               tick;

`ifdef SSC_ADC_TIMEOUT_EN
  localparam int unsigned NB_TO = $clog2(TIMEOUT + 1);
  logic [NB_TO-1:0] conv_cnt_q, conv_cnt_d;
  logic             conv_timeout;

  assign conv_timeout = (conv_cnt_q == NB_TO'(TIMEOUT - 1));
  assign conv_cnt_d   = (state_q == StConvert) ? conv_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!i_rst_n) conv_cnt_q <= '0;
    else          conv_cnt_q <= conv_cnt_d;
  end
`endif

  assign tick = (div_q == i_clk_div);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    ph_d     = ph_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRowRst;
          err_d   = 1'b0;
        end
      end
      StRowRst: begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
        if (tick) state_d = StRowShift;
      end
      // Shift states: phase 0 data setup, phase 1 clock high, phase 2 clock low with data held.
      StRowShift: if (tick && ph_q == NB_PH'(2)) state_d = StColRst;
      StColRst:   if (tick) state_d = StColShift;
      StColShift: if (tick && ph_q == NB_PH'(2)) state_d = StSettle;
      StSettle:   if (tick && ph_q == NB_PH'(SETTLE_TICKS - 1)) state_d = StConvert;
      StConvert: begin
        if (i_adc_done) begin
          sample_d = i_adc_val;
          state_d  = StWrite;
        end
`ifdef SSC_ADC_TIMEOUT_EN
        else if (conv_timeout) begin
          sample_d = '1;
          err_d    = 1'b1;
          state_d  = StWrite;
        end
`endif
      end
      StWrite: begin
        addr_d = addr_q + 1'b1;
        if (col_q < NB_COL'(COLS - 1)) begin
          col_d   = col_q + 1'b1;
          state_d = StColShift;
        end else if (row_q < NB_ROW'(ROWS - 1)) begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          state_d = StRowShift;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = i_continuous ? StRowRst : StIdle;
      default: state_d = StIdle;
    endcase

    if (i_abort) begin
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      addr_d  = '0;
    end

    trig_d = (state_d == StConvert) && (state_q != StConvert);

    // Divider and phase restart on every state change so each state begins on a full tick.
    if (state_d != state_q || state_q == StIdle) begin
      div_d = '0;
      ph_d  = '0;
    end else if (tick) begin
      div_d = '0;
      ph_d  = ph_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      div_q    <= '0;
      ph_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      trig_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      trig_q   <= trig_d;
      err_q    <= err_d;
    end
  end

  assign o_adc_trigger   = trig_q;
  assign o_chip_row_rst  = (state_q == StRowRst);
  assign o_chip_row_clk  = (state_q == StRowShift) && (ph_q == NB_PH'(1));
  assign o_chip_row_data = (state_q == StRowShift) && (row_q == '0);
  assign o_chip_row_ena  = (state_q == StSettle) || (state_q == StConvert) || (state_q == StWrite);
  assign o_chip_col_rst  = (state_q == StColRst);
  assign o_chip_col_clk  = (state_q == StColShift) && (ph_q == NB_PH'(1));
  assign o_chip_col_data = (state_q == StColShift) && (col_q == '0);
  assign o_ram_we        = (state_q == StWrite);
  assign o_chip_key_wren = (state_q == StWrite);
  assign o_key_bit       = (state_q == StWrite) && (sample_q > i_umbral);
  assign o_ram_addr      = addr_q;
  assign o_ram_wdata     = sample_q;
  assign o_busy          = (state_q != StIdle);
  assign o_frame_done    = (state_q == StDone);
`ifdef SSC_ADC_TIMEOUT_EN
  assign o_adc_err       = err_q;
`else
  assign o_adc_err       = 1'b0;
`endif

endmodule

// File: tb/tb_speckle_scan_sequencer.sv
// Directed, table-driven bench for speckle_scan_sequencer on a 4x4 array.
module tb_speckle_scan_sequencer;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 4;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_continuous = 1'b0;
  logic        i_abort = 1'b0;
  logic [23:0] i_clk_div = '0;
  logic [11:0] i_umbral = '0;
  logic [11:0] i_adc_val;
  logic        i_adc_done;
  logic        o_adc_trigger, o_chip_row_clk, o_chip_row_rst, o_chip_row_data, o_chip_row_ena;
  logic        o_chip_col_clk, o_chip_col_rst, o_chip_col_data, o_chip_key_wren, o_key_bit;
  logic        o_ram_we, o_busy, o_frame_done, o_adc_err;
  logic [3:0]  o_ram_addr;
  logic [11:0] o_ram_wdata;

  speckle_scan_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .NB_DATA(12), .NB_DIV(24), .SETTLE_TICKS(2), .TIMEOUT(32)
  ) u_dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_continuous(i_continuous),
    .i_abort(i_abort), .i_clk_div(i_clk_div), .i_umbral(i_umbral), .i_adc_val(i_adc_val),
    .i_adc_done(i_adc_done), .o_adc_trigger(o_adc_trigger), .o_chip_row_clk(o_chip_row_clk),
    .o_chip_row_rst(o_chip_row_rst), .o_chip_row_data(o_chip_row_data),
    .o_chip_row_ena(o_chip_row_ena), .o_chip_col_clk(o_chip_col_clk),
    .o_chip_col_rst(o_chip_col_rst), .o_chip_col_data(o_chip_col_data),
    .o_chip_key_wren(o_chip_key_wren), .o_key_bit(o_key_bit), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_adc_err(o_adc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [11:0] wdata;
    logic        key;
  } vec_t;
  vec_t exp_tab[16];

  // Event logs filled by the monitor; tests index them relative to a snapshot base.
  logic [3:0]  log_addr[256];
  logic [11:0] log_data[256];
  logic        log_key[256];
  logic        row_dat[64];
  logic        col_dat[256];
  int          hi_len[512];
  int n_wr = 0, n_fd = 0, n_rowp = 0, n_colp = 0, n_hi = 0, n_wren_bad = 0;
  int silent_addr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC model: answers addr*16 five cycles after each trigger unless the pixel is silenced.
  initial begin : adc_model
    int pend;
    logic [3:0] pend_addr;
    pend = 0;
    pend_addr = '0;
    i_adc_done = 1'b0;
    i_adc_val = '0;
    forever begin
      @(posedge clk);
      #1;
      i_adc_done = 1'b0;
      if (o_adc_trigger) begin
        pend = 5;
        pend_addr = o_ram_addr;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && int'(pend_addr) != silent_addr) begin
          i_adc_done = 1'b1;
          i_adc_val = {4'b0, pend_addr, 4'b0};
        end
      end
    end
  end

  initial begin : monitor
    logic prev_r, prev_c;
    int run_r, run_c;
    prev_r = 1'b0; prev_c = 1'b0; run_r = 0; run_c = 0;
    forever begin
      @(negedge clk);
      if (o_ram_we) begin
        if (n_wr < 256) begin
          log_addr[n_wr] = o_ram_addr;
          log_data[n_wr] = o_ram_wdata;
          log_key[n_wr]  = o_key_bit;
        end
        n_wr++;
      end
      if (o_ram_we !== o_chip_key_wren) n_wren_bad++;
      if (o_frame_done) n_fd++;
      if (o_chip_row_clk && !prev_r) begin
        if (n_rowp < 64) row_dat[n_rowp] = o_chip_row_data;
        n_rowp++;
      end
      if (o_chip_col_clk && !prev_c) begin
        if (n_colp < 256) col_dat[n_colp] = o_chip_col_data;
        n_colp++;
      end
      if (o_chip_row_clk) run_r++;
      else if (prev_r) begin
        if (n_hi < 512) hi_len[n_hi] = run_r;
        n_hi++;
        run_r = 0;
      end
      if (o_chip_col_clk) run_c++;
      else if (prev_c) begin
        if (n_hi < 512) hi_len[n_hi] = run_c;
        n_hi++;
        run_c = 0;
      end
      prev_r = o_chip_row_clk;
      prev_c = o_chip_col_clk;
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (!o_frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(o_frame_done), 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wb, rb, cb, hb, fb, lo, hi;
    logic found;
    for (int i = 0; i < 16; i++) begin
      exp_tab[i].addr  = 4'(i);
      exp_tab[i].wdata = 12'(i * 16);
      exp_tab[i].key   = (i >= 7);  // 112 is the first sample above 100
    end

    // Reset with start asserted: reset wins.
    i_start = 1'b1;
    settle(3);
    @(negedge clk);
    chk("reset outputs", 32'({o_adc_trigger, o_chip_row_clk, o_chip_row_rst, o_chip_row_data,
        o_chip_row_ena, o_chip_col_clk, o_chip_col_rst, o_chip_col_data, o_chip_key_wren,
        o_key_bit, o_ram_we, o_ram_addr, o_ram_wdata, o_busy, o_frame_done, o_adc_err}), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    i_start = 1'b0;
    settle(1);
    i_rst_n = 1'b1;
    settle(2);
    chk("idle stays idle", 32'(o_busy), 32'd0);

    // Frame at full tick rate with threshold 100.
    i_umbral = 12'd100;
    wb = n_wr; rb = n_rowp; hb = n_hi; fb = n_fd;
    start_frame();
    wait_done("t1 frame_done", 2000);
    settle(3);
    chk("t1 busy after frame", 32'(o_busy), 32'd0);
    chk("t1 write count", 32'(n_wr - wb), 32'd16);
    chk("t1 frame_done count", 32'(n_fd - fb), 32'd1);
    chk("t1 wren vs we", 32'(n_wren_bad), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1 addr[%0d]", i), 32'(log_addr[wb + i]), 32'(exp_tab[i].addr));
      chk($sformatf("t1 wdata[%0d]", i), 32'(log_data[wb + i]), 32'(exp_tab[i].wdata));
      chk($sformatf("t2 key[%0d]", i), 32'(log_key[wb + i]), 32'(exp_tab[i].key));
    end
    chk("t1 row pulses", 32'(n_rowp - rb), 32'd4);
    chk("t1 high len div0", 32'(hi_len[hb]), 32'd1);

    // Divider 3: every chip clock high phase spans four cycles.
    i_clk_div = 24'd3;
    wb = n_wr; rb = n_rowp; cb = n_colp; hb = n_hi;
    start_frame();
    wait_done("t3 frame_done", 5000);
    settle(3);
    chk("t3 write count", 32'(n_wr - wb), 32'd16);
    chk("t3 row pulses", 32'(n_rowp - rb), 32'd4);
    chk("t3 col pulses", 32'(n_colp - cb), 32'd16);
    lo = 999; hi = 0;
    for (int i = hb; i < n_hi; i++) begin
      if (hi_len[i] < lo) lo = hi_len[i];
      if (hi_len[i] > hi) hi = hi_len[i];
    end
    chk("t3 high len min", 32'(lo), 32'd4);
    chk("t3 high len max", 32'(hi), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3 row_data[%0d]", i), 32'(row_dat[rb + i]), 32'(i == 0));
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3 col_data[%0d]", i), 32'(col_dat[cb + i]), 32'(i % 4 == 0));

    // Continuous mode for two frames.
    i_clk_div = 24'd0;
    i_continuous = 1'b1;
    wb = n_wr; fb = n_fd;
    start_frame();
    wait_done("t4 frame1 done", 2000);
    @(negedge clk);
    chk("t4 row_rst after done", 32'(o_chip_row_rst), 32'd1);
    chk("t4 busy after done", 32'(o_busy), 32'd1);
    @(posedge clk); #1 i_continuous = 1'b0;
    wait_done("t4 frame2 done", 2000);
    settle(3);
    chk("t4 write count", 32'(n_wr - wb), 32'd32);
    chk("t4 frame_done count", 32'(n_fd - fb), 32'd2);
    chk("t4 frame2 first addr", 32'(log_addr[wb + 16]), 32'd0);
    chk("t4 frame2 last addr", 32'(log_addr[wb + 31]), 32'd15);
    chk("t4 idle at end", 32'(o_busy), 32'd0);

    // Abort during the conversion of pixel 9.
    wb = n_wr;
    start_frame();
    begin
      int k = 0;
      @(negedge clk);
      while (!(o_adc_trigger && o_ram_addr == 4'd9) && k < 2000) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t5 reached addr 9", 32'(o_adc_trigger && o_ram_addr == 4'd9), 32'd1);
    i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    @(negedge clk);
    chk("t5 busy after abort", 32'(o_busy), 32'd0);
    chk("t5 row_ena after abort", 32'(o_chip_row_ena), 32'd0);
    chk("t5 addr after abort", 32'(o_ram_addr), 32'd0);
    settle(12);
    chk("t5 write count", 32'(n_wr - wb), 32'd9);
    found = 1'b0;
    for (int i = wb; i < n_wr; i++) if (log_addr[i] == 4'd9) found = 1'b1;
    chk("t5 no write at 9", 32'(found), 32'd0);
    chk("t5 still idle", 32'(o_busy), 32'd0);

`ifdef SSC_ADC_TIMEOUT_EN
    // ADC silent on pixel 5: timeout writes all-ones and flags the error.
    silent_addr = 5;
    wb = n_wr;
    start_frame();
    wait_done("t6 frame_done", 3000);
    settle(3);
    chk("t6 write count", 32'(n_wr - wb), 32'd16);
    chk("t6 addr5", 32'(log_addr[wb + 5]), 32'd5);
    chk("t6 wdata5", 32'(log_data[wb + 5]), 32'hFFF);
    chk("t6 wdata6", 32'(log_data[wb + 6]), 32'd96);
    chk("t6 adc_err", 32'(o_adc_err), 32'd1);
    silent_addr = -1;
    start_frame();
    @(negedge clk);
    chk("t6 adc_err cleared", 32'(o_adc_err), 32'd0);
    wait_done("t6 frame2 done", 2000);
`endif

    settle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
